cube_serial_rx: RTL and testbench



---
 rtl/cube_serial_rx.sv | 196 +++++++++++++++++++
 tb/tb_cube_serial_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_serial_rx.sv
// -----------------------------------------------------------------------------
// cube_serial_rx
// Receiving end of the LED-cube serial scan link. It oversamples the
// sclk/rclk/sdio stream on clk, rebuilds the 72-bit words shifted toward the
// 595 chain, and reassembles the eight 64-bit layer images. A frame is
// published once every layer has been latched at least once.
//
// Optional build macro: CUBE_RX_STATS_EN
//   Adds frame_cnt / err_cnt 16-bit wrapping event counters.
//
// Ports
//   clk             system clock
//   rst             asynchronous reset, active-high
//   sclk_in         serial shift clock (asynchronous)
//   rclk_in         latch clock (asynchronous)
//   sdio_in         serial data (asynchronous)
//   layer_1..8      published layer images (held until the next frame)
//   frame_valid     one-cycle pulse when a complete frame is published
//   frame_err       one-cycle pulse on a rejected latch
//   err_len         sticky: latch with wrong bit count
//   err_sel         sticky: select field not exactly one-hot / one-cold
//   frame_cnt       (stats build) published frame count
//   err_cnt         (stats build) rejected latch count
//
// The layer outputs map select bit i to layer_(i+1), so SEL_W is expected to
// stay at 8.
// -----------------------------------------------------------------------------
module cube_serial_rx #(
    parameter int DATA_W         = 64,
    parameter int SEL_W          = 8,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              rclk_in,
    input  logic              sdio_in,
    output logic [DATA_W-1:0] layer_1,
    output logic [DATA_W-1:0] layer_2,
    output logic [DATA_W-1:0] layer_3,
    output logic [DATA_W-1:0] layer_4,
    output logic [DATA_W-1:0] layer_5,
    output logic [DATA_W-1:0] layer_6,
    output logic [DATA_W-1:0] layer_7,
    output logic [DATA_W-1:0] layer_8,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              err_len,
    output logic              err_sel
`ifdef CUBE_RX_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int W     = DATA_W + SEL_W;
    localparam int CNT_W = $clog2(W + 2);
    localparam int IDX_W = $clog2(SEL_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(W + 1);

    // [0] first sync stage, [1] second sync stage, [2] previous second stage
    logic [2:0] sclk_q;
    logic [2:0] rclk_q;
    logic [1:0] sdio_q;

    logic [W-1:0]      sr;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] shadow [SEL_W];
    logic [SEL_W-1:0]  seen;

    logic              sclk_rise;
    logic              rclk_rise;
    logic [W-1:0]      sr_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [SEL_W-1:0]  sel_eff;
    logic              sel_ok;
    logic              len_ok;
    logic [IDX_W-1:0]  sel_idx;
    logic              store;
    logic [SEL_W-1:0]  store_mask;
    logic              seen_full;
    logic [SEL_W-1:0]  seen_next;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign rclk_rise = rclk_q[1] & ~rclk_q[2];

    // A shift coincident with a latch is applied first, so the latch
    // decision looks at the post-shift register and count.
    always_comb begin
        sr_next  = sr;
        cnt_next = bitcnt;
        if (sclk_rise) begin
            sr_next = {sr[W-2:0], sdio_q[1]};
            if (bitcnt != CNT_SAT)
                cnt_next = bitcnt + 1'b1;
        end
    end

    always_comb begin
        if (SEL_ACTIVE_LOW != 0)
            sel_eff = ~sr_next[SEL_W-1:0];
        else
            sel_eff = sr_next[SEL_W-1:0];
        sel_ok = (sel_eff != '0) && ((sel_eff & (sel_eff - 1'b1)) == '0);
        len_ok = (cnt_next == CNT_FULL);
        sel_idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (sel_eff[i])
                sel_idx = IDX_W'(i);
        end
    end

    assign store      = rclk_rise & len_ok & sel_ok;
    assign store_mask = store ? (SEL_W'(1) << sel_idx) : '0;
    assign seen_full  = &seen;
    // A layer stored in the publish cycle starts the next frame's mask.
    assign seen_next  = (seen_full ? '0 : seen) | store_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            rclk_q      <= '0;
            sdio_q      <= '0;
            sr          <= '0;
            bitcnt      <= '0;
            seen        <= '0;
            for (int i = 0; i < SEL_W; i++)
                shadow[i] <= '0;
            layer_1     <= '0;
            layer_2     <= '0;
            layer_3     <= '0;
            layer_4     <= '0;
            layer_5     <= '0;
            layer_6     <= '0;
            layer_7     <= '0;
            layer_8     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_len     <= 1'b0;
            err_sel     <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_in};
            rclk_q <= {rclk_q[1:0], rclk_in};
            sdio_q <= {sdio_q[0], sdio_in};

            sr     <= sr_next;
            bitcnt <= rclk_rise ? '0 : cnt_next;
            seen   <= seen_next;

            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (rclk_rise) begin
                if (!len_ok) begin
                    frame_err <= 1'b1;
                    err_len   <= 1'b1;
                end else if (!sel_ok) begin
                    frame_err <= 1'b1;
                    err_sel   <= 1'b1;
                end else begin
                    shadow[sel_idx] <= sr_next[W-1:SEL_W];
                end
            end

            if (seen_full) begin
                layer_1     <= shadow[0];
                layer_2     <= shadow[1];
                layer_3     <= shadow[2];
                layer_4     <= shadow[3];
                layer_5     <= shadow[4];
                layer_6     <= shadow[5];
                layer_7     <= shadow[6];
                layer_8     <= shadow[7];
                frame_valid <= 1'b1;
            end
        end
    end

`ifdef CUBE_RX_STATS_EN
    // Counters step on the same edge that raises the corresponding pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (seen_full)
                frame_cnt <= frame_cnt + 16'd1;
            if (rclk_rise && !(len_ok && sel_ok))
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cube_serial_rx.sv
module tb_cube_serial_rx;

    typedef struct packed {
        logic             is_frame;
        logic             e_len;
        logic             e_sel;
        logic [7:0][63:0] l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, rclk = 1'b0, sdio = 1'b0;
    logic tgt_b = 1'b0;

    logic sclk_a, rclk_a, sdio_a, sclk_b, rclk_b, sdio_b;
    assign sclk_a = tgt_b ? 1'b0 : sclk;
    assign rclk_a = tgt_b ? 1'b0 : rclk;
    assign sdio_a = tgt_b ? 1'b0 : sdio;
    assign sclk_b = tgt_b ? sclk : 1'b0;
    assign rclk_b = tgt_b ? rclk : 1'b0;
    assign sdio_b = tgt_b ? sdio : 1'b0;

    logic [63:0] a_l1, a_l2, a_l3, a_l4, a_l5, a_l6, a_l7, a_l8;
    logic [63:0] b_l1, b_l2, b_l3, b_l4, b_l5, b_l6, b_l7, b_l8;
    logic a_fv, a_fe, a_el, a_es, b_fv, b_fe, b_el, b_es;
    logic [7:0][63:0] a_lay, b_lay;
    assign a_lay = {a_l8, a_l7, a_l6, a_l5, a_l4, a_l3, a_l2, a_l1};
    assign b_lay = {b_l8, b_l7, b_l6, b_l5, b_l4, b_l3, b_l2, b_l1};
`ifdef CUBE_RX_STATS_EN
    logic [15:0] a_fc, a_ec, b_fc, b_ec;
`endif

    cube_serial_rx #(.DATA_W(64), .SEL_W(8), .SEL_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .sclk_in(sclk_a), .rclk_in(rclk_a), .sdio_in(sdio_a),
        .layer_1(a_l1), .layer_2(a_l2), .layer_3(a_l3), .layer_4(a_l4),
        .layer_5(a_l5), .layer_6(a_l6), .layer_7(a_l7), .layer_8(a_l8),
        .frame_valid(a_fv), .frame_err(a_fe), .err_len(a_el), .err_sel(a_es)
`ifdef CUBE_RX_STATS_EN
        , .frame_cnt(a_fc), .err_cnt(a_ec)
`endif
    );

    cube_serial_rx #(.DATA_W(64), .SEL_W(8), .SEL_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .sclk_in(sclk_b), .rclk_in(rclk_b), .sdio_in(sdio_b),
        .layer_1(b_l1), .layer_2(b_l2), .layer_3(b_l3), .layer_4(b_l4),
        .layer_5(b_l5), .layer_6(b_l6), .layer_7(b_l7), .layer_8(b_l8),
        .frame_valid(b_fv), .frame_err(b_fe), .err_len(b_el), .err_sel(b_es)
`ifdef CUBE_RX_STATS_EN
        , .frame_cnt(b_fc), .err_cnt(b_ec)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic score(input string who, input exp_t e, input logic fv, input logic fe,
                         input logic el, input logic es, input logic [7:0][63:0] lay);
        check({who, " pulse kind {fv,fe}"}, 64'({fv, fe}), 64'({e.is_frame, ~e.is_frame}));
        check({who, " sticky {err_len,err_sel}"}, 64'({el, es}), 64'({e.e_len, e.e_sel}));
        if (e.is_frame) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("%s layer_%0d", who, k + 1), lay[k], e.l[k]);
        end
    endtask

    // Monitors: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (a_fv || a_fe)) begin
            if (qa.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL A unexpected pulse: fv=%b fe=%b expected none", a_fv, a_fe);
            end else begin
                score("A", qa.pop_front(), a_fv, a_fe, a_el, a_es, a_lay);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (b_fv || b_fe)) begin
            if (qb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL B unexpected pulse: fv=%b fe=%b expected none", b_fv, b_fe);
            end else begin
                score("B", qb.pop_front(), b_fv, b_fe, b_el, b_es, b_lay);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdio = b; sclk = 1'b0;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [71:0] w, input int n);
        for (int i = 0; i < n; i++)
            send_bit(w[71 - i]);
    endtask

    task automatic latch();
        rclk = 1'b1;
        wait_clk(4);
        rclk = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_word(input logic [71:0] w);
        send_bits(w, 72);
        latch();
    endtask

    // Last sclk rise lands in the same clk cycle as the rclk rise.
    task automatic send_word_coinc(input logic [71:0] w);
        send_bits(w, 71);
        sdio = w[0]; sclk = 1'b0; rclk = 1'b0;
        wait_clk(4);
        sclk = 1'b1; rclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0; rclk = 1'b0;
        wait_clk(4);
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [7:0] onehot(input int k);
        logic [7:0] one;
        one = 8'h01;
        return one << (k - 1);
    endfunction

    function automatic exp_t frame_exp(input logic [7:0] base, input logic el, input logic es);
        exp_t e;
        e.is_frame = 1'b1; e.e_len = el; e.e_sel = es;
        for (int k = 1; k <= 8; k++)
            e.l[k-1] = rep(base + 8'(k));
        return e;
    endfunction

    function automatic exp_t err_exp(input logic el, input logic es);
        exp_t e;
        e.is_frame = 1'b0; e.e_len = el; e.e_sel = es; e.l = '0;
        return e;
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: %0d/%0d events still pending, expected 0", name, qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t eb;
        wait_clk(3);
        #1;
        check("reset A layers", 64'(|a_lay), 64'd0);
        check("reset A flags", 64'({a_fv, a_fe, a_el, a_es}), 64'd0);
        check("reset B layers", 64'(|b_lay), 64'd0);
        rst = 1'b0;
        wait_clk(3);

        // Frame 1: layer k = {8{k}}, one-hot select.
        qa.push_back(frame_exp(8'h00, 1'b0, 1'b0));
        for (int k = 1; k <= 8; k++)
            send_word({rep(8'(k)), onehot(k)});
        drain("frame1");

        // Frame 2: junk layer 1, short word, overwrite, bad select, coincident last bit.
        send_word({64'hDEADBEEF_CAFEF00D, onehot(1)});
        qa.push_back(err_exp(1'b1, 1'b0));
        send_bits({rep(8'h77), onehot(2)}, 71);
        latch();
        drain("short word");
        for (int k = 1; k <= 7; k++)
            send_word({rep(8'h10 + 8'(k)), onehot(k)});
        qa.push_back(err_exp(1'b1, 1'b1));
        send_word({64'hFFFF_FFFF_FFFF_FFFF, 8'b0000_0011});
        drain("bad select");
        qa.push_back(frame_exp(8'h10, 1'b1, 1'b1));
        send_word_coinc({rep(8'h18), onehot(8)});
        drain("frame2");
`ifdef CUBE_RX_STATS_EN
        check("frame_cnt after 2 frames", 64'(a_fc), 64'd2);
        check("err_cnt after 2 errors", 64'(a_ec), 64'd2);
`endif

        // Partial frame, then reset mid-frame.
        for (int k = 1; k <= 5; k++)
            send_word({rep(8'hA0 + 8'(k)), onehot(k)});
        rst = 1'b1;
        #1;
        check("mid-frame reset layers", 64'(|a_lay), 64'd0);
        check("mid-frame reset flags", 64'({a_fv, a_fe, a_el, a_es}), 64'd0);
`ifdef CUBE_RX_STATS_EN
        check("reset counters", 64'({a_fc, a_ec}), 64'd0);
`endif
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);

        qa.push_back(frame_exp(8'h20, 1'b0, 1'b0));
        for (int k = 1; k <= 8; k++)
            send_word({rep(8'h20 + 8'(k)), onehot(k)});
        drain("frame after reset");
`ifdef CUBE_RX_STATS_EN
        check("frame_cnt after reset frame", 64'(a_fc), 64'd1);
        check("err_cnt after reset frame", 64'(a_ec), 64'd0);
`endif

        // One-cold select on instance B.
        tgt_b = 1'b1;
        wait_clk(4);
        eb = frame_exp(8'h30, 1'b0, 1'b0);
        eb.l[0] = 64'h0123_4567_89AB_CDEF;
        qb.push_back(eb);
        send_word({64'h0123_4567_89AB_CDEF, 8'b1111_1110});
        for (int k = 2; k <= 8; k++)
            send_word({rep(8'h30 + 8'(k)), ~onehot(k)});
        drain("one-cold frame");
        tgt_b = 1'b0;
        wait_clk(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
